// File: rtl/ship_placement_round_pkg.sv
// Shared definitions for the ship placement round.
// - Map geometry: COLUNE_SIZE cells per column, TOTAL_COLUNES columns, DATA_WIDTH map bits.
// - cell_index(): converts a 1-based (x, y) cell to its bit position in the map.
// - state_e: placement FSM states.
package ship_placement_round_pkg;

  localparam int unsigned COLUNE_SIZE   = 7;
  localparam int unsigned TOTAL_COLUNES = 5;
  localparam int unsigned DATA_WIDTH    = TOTAL_COLUNES * COLUNE_SIZE;

  // Longest ship a 3-bit size code can describe.
  localparam int unsigned MAX_SHIP_SIZE = 7;

  typedef enum logic [2:0] {
    StIdle,
    StPlace,
    StCheck,
    StCommit,
    StReject,
    StDone
  } state_e;

  // Column x=1 occupies the top bits, x=TOTAL_COLUNES the bottom bits.
  // Only valid for x in 1..TOTAL_COLUNES and y in 1..COLUNE_SIZE.
  function automatic logic [5:0] cell_index(input logic [3:0] x, input logic [3:0] y);
    int unsigned idx;
    idx = (TOTAL_COLUNES - 32'(x)) * COLUNE_SIZE + 32'(y) - 1;
    return idx[5:0];
  endfunction

endpackage

// File: rtl/d_flipflop.sv
// Single D flip-flop with asynchronous active-low reset and selectable reset value.
// Ports:
//   clk_i  - clock, rising edge
//   rst_ni - asynchronous reset, active low
//   d_i    - data in
//   q_o    - registered data out
module d_flipflop #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o <= ResetVal;
    end else begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/ship_mask_gen.sv
// Combinational ship footprint generator.
// Ports:
//   x_i         - anchor column code (valid 1..5)
//   y_i         - anchor row code (valid 1..7)
//   orient_i    - 0: cells grow along x, 1: cells grow along y
//   size_i      - ship length in cells
//   mask_o      - map bits covered by the ship; cells outside the board are dropped
//   in_bounds_o - 1 when the anchor and every ship cell lie on the board
module ship_mask_gen
  import ship_placement_round_pkg::*;
(
  input  logic [2:0]            x_i,
  input  logic [2:0]            y_i,
  input  logic                  orient_i,
  input  logic [2:0]            size_i,
  output logic [DATA_WIDTH-1:0] mask_o,
  output logic                  in_bounds_o
);

  // 4-bit arithmetic so that code 7 + size 3 does not wrap back onto the board.
  logic [3:0] x_w, y_w, size_w, x_end, y_end;

  assign x_w    = {1'b0, x_i};
  assign y_w    = {1'b0, y_i};
  assign size_w = {1'b0, size_i};

  assign x_end = orient_i ? x_w : x_w + size_w - 4'd1;
  assign y_end = orient_i ? y_w + size_w - 4'd1 : y_w;

  assign in_bounds_o = (x_w >= 4'd1) && (x_w <= 4'(TOTAL_COLUNES)) &&
                       (y_w >= 4'd1) && (y_w <= 4'(COLUNE_SIZE)) &&
                       (x_end <= 4'(TOTAL_COLUNES)) && (y_end <= 4'(COLUNE_SIZE));

  always_comb begin
    logic [3:0] cx;
    logic [3:0] cy;
    mask_o = '0;
    cx     = '0;
    cy     = '0;
    for (int unsigned k = 0; k < MAX_SHIP_SIZE; k++) begin
      cx = orient_i ? x_w : x_w + 4'(k);
      cy = orient_i ? y_w + 4'(k) : y_w;
      if ((4'(k) < size_w) &&
          (cx >= 4'd1) && (cx <= 4'(TOTAL_COLUNES)) &&
          (cy >= 4'd1) && (cy <= 4'(COLUNE_SIZE))) begin
        mask_o[cell_index(cx, cy)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ship_placement_round.sv
// Setup-phase ship placement: the player places NUM_SHIPS ships one at a time, each placement
// is checked for bounds and overlap, then committed or rejected with an LED verdict.
// Ports:
//   clk          - system clock, rising edge
//   reset        - asynchronous reset, active low
//   enable       - round enable; low returns to idle and clears the map
//   x_coord_code - anchor column code (1..5)
//   y_coord_code - anchor row code (1..7)
//   orientation  - 0 horizontal (x increasing), 1 vertical (y increasing)
//   confirm_n    - active-low placement button, asynchronous to clk
//   selected_map - committed ship map
//   matriz_data  - display map: committed map plus candidate cells while placing
//   ship_index   - index of the ship being placed
//   map_ready    - high once all ships are placed
//   ledRgb       - [0] green accepted, [1] red rejected
module ship_placement_round
  import ship_placement_round_pkg::*;
#(
  parameter int unsigned              NUM_SHIPS  = 3,
  parameter logic [3*NUM_SHIPS-1:0]   SHIP_SIZES = {3'd1, 3'd2, 3'd3},
  parameter int unsigned              LED_HOLD   = 25_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [2:0]            x_coord_code,
  input  logic [2:0]            y_coord_code,
  input  logic                  orientation,
  input  logic                  confirm_n,
  output logic [DATA_WIDTH-1:0] selected_map,
  output logic [DATA_WIDTH-1:0] matriz_data,
  output logic [1:0]            ship_index,
  output logic                  map_ready,
  output logic [1:0]            ledRgb
);

  localparam int unsigned      LedW      = $clog2(LED_HOLD + 1);
  localparam logic [LedW-1:0]  LedLoad   = LedW'(LED_HOLD);
  localparam logic [1:0]       LedGreen  = 2'b01;
  localparam logic [1:0]       LedRed    = 2'b10;
  localparam logic [1:0]       LastShip  = 2'(NUM_SHIPS - 1);

  state_e                state_q;
  logic [DATA_WIDTH-1:0] map_q;
  logic [DATA_WIDTH-1:0] mask_q;
  logic [1:0]            ship_idx_q;
  logic [LedW-1:0]       led_cnt_q;
  logic [1:0]            led_color_q;

  // Button synchronizer; idle level is high so reset does not fake a press.
  logic sync1, sync2, sync_prev, press;

  d_flipflop #(.ResetVal(1'b1)) u_sync1 (
    .clk_i  (clk),
    .rst_ni (reset),
    .d_i    (confirm_n),
    .q_o    (sync1)
  );

  d_flipflop #(.ResetVal(1'b1)) u_sync2 (
    .clk_i  (clk),
    .rst_ni (reset),
    .d_i    (sync1),
    .q_o    (sync2)
  );

  d_flipflop #(.ResetVal(1'b1)) u_edge (
    .clk_i  (clk),
    .rst_ni (reset),
    .d_i    (sync2),
    .q_o    (sync_prev)
  );

  assign press = sync_prev & ~sync2;

  // Size of the ship currently being placed.
  logic [2:0] ship_size;

  always_comb begin
    ship_size = '0;
    for (int unsigned i = 0; i < NUM_SHIPS; i++) begin
      if (ship_idx_q == 2'(i)) begin
        ship_size = SHIP_SIZES[3*i +: 3];
      end
    end
  end

  logic [DATA_WIDTH-1:0] cand_mask;
  logic                  cand_in_bounds;
  logic                  cand_valid;

  ship_mask_gen u_mask_gen (
    .x_i         (x_coord_code),
    .y_i         (y_coord_code),
    .orient_i    (orientation),
    .size_i      (ship_size),
    .mask_o      (cand_mask),
    .in_bounds_o (cand_in_bounds)
  );

  assign cand_valid = cand_in_bounds && ((cand_mask & map_q) == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      map_q       <= '0;
      mask_q      <= '0;
      ship_idx_q  <= '0;
      led_cnt_q   <= '0;
      led_color_q <= '0;
    end else if (!enable) begin
      state_q     <= StIdle;
      map_q       <= '0;
      mask_q      <= '0;
      ship_idx_q  <= '0;
      led_cnt_q   <= '0;
      led_color_q <= '0;
    end else begin
      // A verdict load below overrides the countdown.
      if (led_cnt_q != '0) begin
        led_cnt_q <= led_cnt_q - LedW'(1);
      end
      unique case (state_q)
        StIdle: begin
          state_q <= StPlace;
        end
        StPlace: begin
          if (press) begin
            state_q <= StCheck;
          end
        end
        StCheck: begin
          mask_q  <= cand_mask;
          state_q <= cand_valid ? StCommit : StReject;
        end
        StCommit: begin
          map_q       <= map_q | mask_q;
          led_cnt_q   <= LedLoad;
          led_color_q <= LedGreen;
          if (ship_idx_q == LastShip) begin
            state_q <= StDone;
          end else begin
            ship_idx_q <= ship_idx_q + 2'd1;
            state_q    <= StPlace;
          end
        end
        StReject: begin
          led_cnt_q   <= LedLoad;
          led_color_q <= LedRed;
          state_q     <= StPlace;
        end
        StDone: begin
          state_q <= StDone;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign selected_map = map_q;
  assign ship_index   = ship_idx_q;
  assign map_ready    = (state_q == StDone);
  assign ledRgb       = (led_cnt_q != '0) ? led_color_q : 2'b00;

  always_comb begin
    matriz_data = map_q;
    if (state_q == StIdle) begin
      matriz_data = '0;
    end else if (state_q == StPlace) begin
      matriz_data = map_q | cand_mask;
    end
  end

endmodule

// File: tb/tb_ship_placement_round.sv
module tb_ship_placement_round;

  localparam int unsigned LedHold = 4;
  localparam int          NShips  = 3;

  localparam int PhIdle    = 0;
  localparam int PhPlace   = 1;
  localparam int PhCheck   = 2;
  localparam int PhVerdict = 3;
  localparam int PhDone    = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [2:0]  x_code = 3'd0;
  logic [2:0]  y_code = 3'd0;
  logic        orientation = 1'b0;
  logic        confirm_n = 1'b1;
  logic [34:0] selected_map;
  logic [34:0] matriz_data;
  logic [1:0]  ship_index;
  logic        map_ready;
  logic [1:0]  ledRgb;

  always #5 clk = ~clk;

  ship_placement_round #(
    .NUM_SHIPS  (3),
    .SHIP_SIZES ({3'd1, 3'd2, 3'd3}),
    .LED_HOLD   (LedHold)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .x_coord_code (x_code),
    .y_coord_code (y_code),
    .orientation  (orientation),
    .confirm_n    (confirm_n),
    .selected_map (selected_map),
    .matriz_data  (matriz_data),
    .ship_index   (ship_index),
    .map_ready    (map_ready),
    .ledRgb       (ledRgb)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- behavioural model ----------------
  int   sizes [NShips] = '{3, 2, 1};
  bit   grid [6][8];
  int   m_phase;
  int   m_idx;
  int   led_left;
  logic [1:0] led_col;
  bit   h0, h1, h2;
  bit   pend_ok;
  int   pend_x, pend_y, pend_o, pend_size;

  function automatic logic [34:0] cell_bit(int x, int y);
    logic [34:0] b;
    b = '0;
    b[(5 - x) * 7 + (y - 1)] = 1'b1;
    return b;
  endfunction

  function automatic logic [34:0] candidate(int x, int y, int o, int size);
    logic [34:0] m;
    int cx, cy;
    m = '0;
    for (int k = 0; k < size; k++) begin
      cx = (o != 0) ? x : x + k;
      cy = (o != 0) ? y + k : y;
      if (cx >= 1 && cx <= 5 && cy >= 1 && cy <= 7) m |= cell_bit(cx, cy);
    end
    return m;
  endfunction

  function automatic bit placement_ok(int x, int y, int o, int size);
    int cx, cy;
    for (int k = 0; k < size; k++) begin
      cx = (o != 0) ? x : x + k;
      cy = (o != 0) ? y + k : y;
      if (cx < 1 || cx > 5 || cy < 1 || cy > 7) return 1'b0;
      if (grid[cx][cy]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [34:0] model_map();
    logic [34:0] m;
    m = '0;
    for (int x = 1; x <= 5; x++)
      for (int y = 1; y <= 7; y++)
        if (grid[x][y]) m |= cell_bit(x, y);
    return m;
  endfunction

  task automatic model_clear();
    for (int x = 0; x < 6; x++)
      for (int y = 0; y < 8; y++)
        grid[x][y] = 1'b0;
    m_phase  = PhIdle;
    m_idx    = 0;
    led_left = 0;
    led_col  = 2'b00;
  endtask

  initial begin
    model_clear();
    h0 = 1'b1; h1 = 1'b1; h2 = 1'b1;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        model_clear();
        h0 = 1'b1; h1 = 1'b1; h2 = 1'b1;
      end else begin
        bit press;
        press = h2 && !h1;
        h2 = h1; h1 = h0; h0 = confirm_n;
        if (led_left > 0) led_left--;
        if (!enable) begin
          model_clear();
        end else begin
          case (m_phase)
            PhIdle:  m_phase = PhPlace;
            PhPlace: if (press) m_phase = PhCheck;
            PhCheck: begin
              pend_x    = int'(x_code);
              pend_y    = int'(y_code);
              pend_o    = int'(orientation);
              pend_size = sizes[m_idx];
              pend_ok   = placement_ok(pend_x, pend_y, pend_o, pend_size);
              m_phase   = PhVerdict;
            end
            PhVerdict: begin
              led_left = LedHold;
              if (pend_ok) begin
                for (int k = 0; k < pend_size; k++) begin
                  if (pend_o != 0) grid[pend_x][pend_y + k] = 1'b1;
                  else grid[pend_x + k][pend_y] = 1'b1;
                end
                led_col = 2'b01;
                if (m_idx == NShips - 1) begin
                  m_phase = PhDone;
                end else begin
                  m_idx++;
                  m_phase = PhPlace;
                end
              end else begin
                led_col = 2'b10;
                m_phase = PhPlace;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // ---------------- literal expectations (handed to the compare process) ----------------
  int          lit_seq = 0;
  string       lit_name;
  logic [34:0] lit_map;
  int          lit_idx;
  bit          lit_ready;
  logic [1:0]  lit_led;

  task automatic expect_lit(string nm, logic [34:0] map, int idx, bit rdy, logic [1:0] led);
    lit_name  = nm;
    lit_map   = map;
    lit_idx   = idx;
    lit_ready = rdy;
    lit_led   = led;
    lit_seq++;
  endtask

  // ---------------- compare process ----------------
  int lit_done = 0;

  task automatic check(string nm, logic [34:0] act, logic [34:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      logic [34:0] exp_map, exp_mat;
      logic [1:0]  exp_led;
      @(negedge clk);
      exp_map = model_map();
      exp_mat = (m_phase == PhPlace) ?
                exp_map | candidate(int'(x_code), int'(y_code), int'(orientation), sizes[m_idx]) :
                ((m_phase == PhIdle) ? 35'd0 : exp_map);
      exp_led = (led_left > 0) ? led_col : 2'b00;
      check("selected_map", selected_map, exp_map);
      check("matriz_data", matriz_data, exp_mat);
      check("ship_index", 35'(ship_index), 35'(m_idx));
      check("map_ready", 35'(map_ready), 35'(m_phase == PhDone));
      check("ledRgb", 35'(ledRgb), 35'(exp_led));
      if (lit_seq != lit_done) begin
        lit_done = lit_seq;
        check({lit_name, ".map"}, selected_map, lit_map);
        check({lit_name, ".model_map"}, exp_map, lit_map);
        check({lit_name, ".idx"}, 35'(ship_index), 35'(lit_idx));
        check({lit_name, ".ready"}, 35'(map_ready), 35'(lit_ready));
        check({lit_name, ".led"}, 35'(ledRgb), 35'(lit_led));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Verdict is visible on the 5th cycle after confirm_n falls.
  task automatic place(string nm, int x, int y, int o, int hold,
                       logic [1:0] led, logic [34:0] map, int idx, bit rdy);
    int last;
    x_code      = 3'(x);
    y_code      = 3'(y);
    orientation = 1'(o);
    confirm_n   = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == hold) confirm_n = 1'b1;
    end
    expect_lit(nm, map, idx, rdy, led);
    last = ((hold > 6) ? hold : 6) + 6;
    for (int k = 6; k <= last; k++) begin
      tick();
      if (k == hold) confirm_n = 1'b1;
    end
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b1;
    tick();
    expect_lit("after_reset", 35'd0, 0, 1'b0, 2'b00);
    tick();
    enable = 1'b1;
    repeat (2) tick();

    place("ship0_first", 1, 1, 0, 1, 2'b01, 35'h010204000, 1, 1'b0);

    // Asynchronous reset mid-placement with a non-empty map.
    x_code = 3'd2; y_code = 3'd1; orientation = 1'b1;
    @(posedge clk);
    #3 reset = 1'b0;
    expect_lit("reset_mid_place", 35'd0, 0, 1'b0, 2'b00);
    tick();
    tick();
    reset = 1'b1;
    repeat (2) tick();

    place("ship0", 1, 1, 0, 1, 2'b01, 35'h010204000, 1, 1'b0);
    place("ship1_overlap", 2, 1, 1, 2, 2'b10, 35'h010204000, 1, 1'b0);
    place("ship1_oob", 5, 3, 0, 1, 2'b10, 35'h010204000, 1, 1'b0);
    place("ship1_held", 5, 6, 1, 10, 2'b01, 35'h010204060, 2, 1'b0);
    place("ship2", 3, 7, 0, 1, 2'b01, 35'h010304060, 2, 1'b1);
    place("done_ignore", 1, 1, 0, 1, 2'b00, 35'h010304060, 2, 1'b1);

    enable = 1'b0;
    tick();
    expect_lit("disable_done", 35'd0, 0, 1'b0, 2'b00);
    tick();
    enable = 1'b1;
    tick();

    // Randomized placements, jitter on coordinates, enable drops and resets.
    for (int it = 0; it < 300; it++) begin
      int r, hold, gap;
      r = int'($urandom_range(0, 39));
      if (r == 0) begin
        @(posedge clk);
        #3 reset = 1'b0;
        tick();
        reset = 1'b1;
      end else if (r < 3 || (map_ready && r < 25)) begin
        enable = 1'b0;
        tick();
        tick();
        enable = 1'b1;
      end
      x_code      = 3'($urandom_range(0, 7));
      y_code      = 3'($urandom_range(0, 7));
      orientation = 1'($urandom_range(0, 1));
      hold = int'($urandom_range(1, 6));
      confirm_n = 1'b0;
      for (int k = 0; k < hold; k++) begin
        tick();
        if ($urandom_range(0, 3) == 0) x_code = 3'($urandom_range(0, 7));
        if (r == 5 && k == 0) confirm_n = 1'b1;
        else if (r == 5 && k == 1) confirm_n = 1'b0;
      end
      confirm_n = 1'b1;
      gap = int'($urandom_range(1, 8));
      for (int k = 0; k < gap; k++) begin
        tick();
        if ($urandom_range(0, 5) == 0) y_code = 3'($urandom_range(0, 7));
      end
    end

    repeat (10) tick();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
